// File: rtl/clock_edge_meter.sv
// clock_edge_meter
// Samples a slow asynchronous clock-like input in the system clock domain,
// emits one-cycle rise/fall strobes, measures high/low phase lengths, reports
// each complete period and flags timeout when no edge arrives in time.
// Optional feature macro: CLOCK_EDGE_METER_LOCK_EN builds the period
// comparator that drives `locked`; without it `locked` is tied low.
module clock_edge_meter #(
  parameter int MaxCount  = 1024,
  parameter int Tolerance = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          slowClock,
  input  logic                          enable,
  output logic                          risePulse,
  output logic                          fallPulse,
  output logic [$clog2(MaxCount+1)-1:0] highCount,
  output logic [$clog2(MaxCount+1)-1:0] lowCount,
  output logic                          periodValid,
  output logic                          locked,
  output logic                          timeout
);
  localparam int W = $clog2(MaxCount + 1);
  localparam logic [W-1:0] MaxW = W'(MaxCount);
  localparam logic [W-1:0] OneW = W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RISE,
    S_MEAS_HIGH,
    S_MEAS_LOW
  } state_t;

  state_t       r_state;
  state_t       w_stateNext;
  logic         r_s0;
  logic         r_s1;
  logic         r_prev;
  logic         w_rise;
  logic         w_fall;
  logic [W-1:0] r_count;
  logic [W-1:0] w_countNext;
  logic         w_captureHigh;
  logic         w_captureLow;
  logic         w_timeoutEvt;

  // Edges are judged on the synchronized level against its one-cycle history.
  assign w_rise = r_s1 & ~r_prev;
  assign w_fall = ~r_s1 & r_prev;

  // Two-flop synchronizer plus history flop; runs regardless of enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s0   <= 1'b0;
      r_s1   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s0   <= slowClock;
      r_s1   <= r_s0;
      r_prev <= r_s1;
    end
  end

  // Measurement state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state, counter update and capture/timeout decisions. An edge seen in
  // the same cycle the counter sits at MaxCount takes priority over timeout.
  always_comb begin
    w_stateNext   = r_state;
    w_countNext   = r_count;
    w_captureHigh = 1'b0;
    w_captureLow  = 1'b0;
    w_timeoutEvt  = 1'b0;
    if (!enable) begin
      w_stateNext = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_stateNext = S_WAIT_RISE;
        end
        S_WAIT_RISE: begin
          if (w_rise) begin
            w_stateNext = S_MEAS_HIGH;
            w_countNext = OneW;
          end
        end
        S_MEAS_HIGH: begin
          if (w_fall) begin
            w_captureHigh = 1'b1;
            w_countNext   = OneW;
            w_stateNext   = S_MEAS_LOW;
          end else if (r_count == MaxW) begin
            w_timeoutEvt = 1'b1;
            w_countNext  = '0;
            w_stateNext  = S_WAIT_RISE;
          end else begin
            w_countNext = r_count + OneW;
          end
        end
        S_MEAS_LOW: begin
          if (w_rise) begin
            w_captureLow = 1'b1;
            w_countNext  = OneW;
            w_stateNext  = S_MEAS_HIGH;
          end else if (r_count == MaxW) begin
            w_timeoutEvt = 1'b1;
            w_countNext  = '0;
            w_stateNext  = S_WAIT_RISE;
          end else begin
            w_countNext = r_count + OneW;
          end
        end
        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end
  end

  // Counter, strobes, captured phase lengths and sticky timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      risePulse   <= 1'b0;
      fallPulse   <= 1'b0;
      periodValid <= 1'b0;
      highCount   <= '0;
      lowCount    <= '0;
      timeout     <= 1'b0;
    end else begin
      r_count     <= w_countNext;
      risePulse   <= enable & w_rise;
      fallPulse   <= enable & w_fall;
      periodValid <= w_captureLow;
      if (w_captureHigh) begin
        highCount <= r_count;
      end
      if (w_captureLow) begin
        lowCount <= r_count;
      end
      if (w_timeoutEvt) begin
        timeout <= 1'b1;
      end else if (enable && w_rise && (r_state != S_IDLE)) begin
        timeout <= 1'b0;
      end
    end
  end

`ifdef CLOCK_EDGE_METER_LOCK_EN
  localparam logic [W:0] TolW = (W+1)'(Tolerance);

  logic [W:0] w_period;
  logic [W:0] w_diff;
  logic [W:0] r_periodPrev;
  logic       r_periodHave;

  // Period is one bit wider than the counts so the sum never wraps.
  assign w_period = {1'b0, highCount} + {1'b0, lowCount};
  assign w_diff   = (w_period >= r_periodPrev) ? (w_period - r_periodPrev)
                                               : (r_periodPrev - w_period);

  // Lock tracking: the first period after a fresh start is only stored;
  // later ones are compared with their predecessor one cycle after capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_periodPrev <= '0;
      r_periodHave <= 1'b0;
      locked       <= 1'b0;
    end else if (!enable || (r_state == S_IDLE) || (r_state == S_WAIT_RISE)) begin
      r_periodHave <= 1'b0;
      locked       <= 1'b0;
    end else if (w_timeoutEvt) begin
      r_periodHave <= 1'b0;
      locked       <= 1'b0;
    end else if (periodValid) begin
      r_periodPrev <= w_period;
      r_periodHave <= 1'b1;
      locked       <= r_periodHave && (w_diff <= TolW);
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule
